track_tile_buffer: RTL and testbench

- Downstream of the pixel-to-track locator. Holds a scrolling ring buffer of track rows with LANES tiles per row.
- Takes the locator's lane and row indices for the current pixel and returns the tile type two cycles later, for the colour mixer.
- Generates new rows from an LFSR as the ball advances, and clears collected coins on request.

---
 rtl/track_tile_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_track_tile_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_tile_buffer.sv
// track_tile_buffer: scrolling ring of track rows feeding the colour mixer.
//   clk, rst_n           clock, async active-low reset
//   advance_row          ball crossed a row boundary (queues one new row)
//   index_x/index_y      lane / relative row of the current pixel
//   pix_valid            lookup request; tile_out/tile_valid follow 2 cycles later
//   clr_valid/x/y        coin-clear request, accepted while clr_ready=1
//   base_row             count of rows retired (mod 2048)
//   busy                 FSM not idle
// Row 0 of the ring (slot head) is the ball row. New rows come from a
// Galois LFSR; a row is never allowed to be entirely obstacles.

// Maps a raw 2-bit LFSR field to a tile type (3 is folded to empty).
module track_tile_lane (
  input  logic [1:0] raw,
  output logic [1:0] tile
);
  assign tile = (raw == 2'd3) ? 2'd0 : raw;
endmodule

module track_tile_buffer #(
  parameter int          ROWS      = 16,
  parameter int          LANES     = 5,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SAFE_ROWS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance_row,
  input  logic [2:0]  index_x,
  input  logic [10:0] index_y,
  input  logic        pix_valid,
  output logic [1:0]  tile_out,
  output logic        tile_valid,
  input  logic        clr_valid,
  input  logic [2:0]  clr_x,
  input  logic [10:0] clr_y,
  output logic        clr_ready,
  output logic [10:0] base_row,
  output logic        busy
);
  localparam int RW = $clog2(ROWS);

  typedef logic [LANES-1:0][1:0] row_t;
  typedef enum logic [2:0] {INIT_GEN, INIT_WR, IDLE, GEN, WR, CLR} state_t;

  state_t         state, state_nxt;
  logic [15:0]    lfsr, lfsr_nxt;
  logic [RW-1:0]  head, init_cnt;
  logic [1:0]     pending, pending_nxt;
  logic [2:0]     clr_x_q;
  logic [10:0]    clr_y_q;
  row_t           mem [ROWS];

  // ---------------- row generation ----------------
  row_t       raw_row, gen_row, new_row;
  logic       all_obs;
  logic [2:0] force_lane;

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign raw_row[g] = lfsr[2*g +: 2];
    track_tile_lane u_lane (.raw(raw_row[g]), .tile(gen_row[g]));
  end

  // Generated in the cycle after the step, so lfsr already holds the post-step value.
  always_comb begin
    new_row    = gen_row;
    all_obs    = 1'b1;
    force_lane = 3'(int'(lfsr[15:13]) % LANES);
    for (int l = 0; l < LANES; l++)
      if (gen_row[l] != 2'd2) all_obs = 1'b0;
    if (all_obs) new_row[force_lane] = 2'd0;
  end

  // ---------------- coin clear ----------------
  logic [RW-1:0] clr_slot;
  row_t          clr_row, clr_wrow;
  logic          clr_hit;

  always_comb begin
    clr_slot = head + clr_y_q[RW-1:0];
    clr_row  = mem[clr_slot];
    clr_wrow = clr_row;
    clr_hit  = 1'b0;
    if (clr_y_q < 11'(ROWS) && clr_x_q < 3'(LANES)) begin
      clr_hit           = (clr_row[clr_x_q] == 2'd1);
      clr_wrow[clr_x_q] = 2'd0;
    end
  end

  // ---------------- FSM ----------------
  logic          lfsr_step, mem_we, adv_head, clr_take;
  logic [RW-1:0] mem_wslot;
  row_t          mem_wdata;

  always_comb begin
    state_nxt = state;
    lfsr_step = 1'b0;
    mem_we    = 1'b0;
    mem_wslot = head;
    mem_wdata = new_row;
    adv_head  = 1'b0;
    clr_take  = 1'b0;
    case (state)
      INIT_GEN: begin
        lfsr_step = 1'b1;
        state_nxt = INIT_WR;
      end
      INIT_WR: begin
        mem_we    = 1'b1;
        mem_wslot = init_cnt;
        if (int'(init_cnt) < SAFE_ROWS) mem_wdata = '0;
        state_nxt = (init_cnt == RW'(ROWS-1)) ? IDLE : INIT_GEN;
      end
      IDLE: begin
        if (pending != 2'd0) state_nxt = GEN;
        else if (clr_valid) begin
          clr_take  = 1'b1;
          state_nxt = CLR;
        end
      end
      GEN: begin
        lfsr_step = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        // slot head holds the row just retired; it becomes the new far row
        mem_we    = 1'b1;
        adv_head  = 1'b1;
        state_nxt = IDLE;
      end
      CLR: begin
        if (clr_hit) begin
          mem_we    = 1'b1;
          mem_wslot = clr_slot;
          mem_wdata = clr_wrow;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating row request counter; a WR consuming one frees room for a new pulse.
  logic pend_inc;
  always_comb begin
    pend_inc    = advance_row && (pending != 2'd3 || adv_head);
    pending_nxt = pending;
    if (pend_inc && !adv_head)      pending_nxt = pending + 2'd1;
    else if (!pend_inc && adv_head) pending_nxt = pending - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_GEN;
      lfsr     <= SEED;
      head     <= '0;
      init_cnt <= '0;
      pending  <= 2'd0;
      base_row <= 11'd0;
      clr_x_q  <= 3'd0;
      clr_y_q  <= 11'd0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (lfsr_step)         lfsr     <= lfsr_nxt;
      if (state == INIT_WR)  init_cnt <= init_cnt + 1'b1;
      if (adv_head) begin
        head     <= head + 1'b1;
        base_row <= base_row + 11'd1;
      end
      if (clr_take) begin
        clr_x_q <= clr_x;
        clr_y_q <= clr_y;
      end
    end
  end

  // No reset: contents are rebuilt by INIT.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wslot] <= mem_wdata;
  end

  // ---------------- lookup pipeline ----------------
  logic [2:1]    vld_pipe;
  logic [RW-1:0] slot_q;
  logic [2:0]    lane_q;
  logic          ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      slot_q   <= '0;
      lane_q   <= 3'd0;
      ok_q     <= 1'b0;
      tile_out <= 2'd0;
    end else begin
      vld_pipe <= {vld_pipe[1], pix_valid};
      slot_q   <= head + index_y[RW-1:0];
      lane_q   <= index_x;
      ok_q     <= pix_valid && index_y < 11'(ROWS) && index_x < 3'(LANES);
      tile_out <= ok_q ? mem[slot_q][lane_q] : 2'd0;
    end
  end

  assign tile_valid = vld_pipe[2];
  assign busy       = (state != IDLE);
  assign clr_ready  = (state == IDLE) && (pending == 2'd0);

endmodule

// File: tb/tb_track_tile_buffer.sv
module tb_track_tile_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        advance_row, pix_valid, clr_valid;
  logic [2:0]  index_x, clr_x;
  logic [10:0] index_y, clr_y;
  logic [1:0]  tile_out;
  logic        tile_valid, clr_ready, busy;
  logic [10:0] base_row;

  track_tile_buffer dut (
    .clk(clk), .rst_n(rst_n), .advance_row(advance_row),
    .index_x(index_x), .index_y(index_y), .pix_valid(pix_valid),
    .tile_out(tile_out), .tile_valid(tile_valid),
    .clr_valid(clr_valid), .clr_x(clr_x), .clr_y(clr_y),
    .clr_ready(clr_ready), .base_row(base_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: mtile[y][x] is the tile at relative row y, lane x.
  int       mtile [16][5];
  bit [15:0] mlfsr;

  task automatic chk(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic bit [15:0] lstep(input bit [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic gen_into(input int yy, input bit zero);
    int all2 = 1;
    for (int l = 0; l < 5; l++) begin
      int r = int'((mlfsr >> (2*l)) & 16'd3);
      if (r == 3) r = 0;
      if (r != 2) all2 = 0;
      mtile[yy][l] = zero ? 0 : r;
    end
    if (all2 == 1 && !zero) mtile[yy][int'(mlfsr >> 13) % 5] = 0;
  endtask

  task automatic model_init();
    mlfsr = 16'hACE1;
    for (int k = 0; k < 16; k++) begin
      mlfsr = lstep(mlfsr);
      gen_into(k, k < 3);
    end
  endtask

  task automatic model_adv();
    mlfsr = lstep(mlfsr);
    for (int y = 0; y < 15; y++)
      for (int l = 0; l < 5; l++) mtile[y][l] = mtile[y+1][l];
    gen_into(15, 1'b0);
  endtask

  // Single lookup starting and ending on a negedge with an empty pipe.
  task automatic lookup(input logic [2:0] x, input logic [10:0] y, input logic pv,
                        output int t, output int v);
    index_x = x; index_y = y; pix_valid = pv;
    @(negedge clk);
    pix_valid = 1'b0;
    chk("lookup_latency_valid", int'(tile_valid), 0);
    @(negedge clk);
    t = int'(tile_out);
    v = int'(tile_valid);
  endtask

  task automatic check_all(input string tag);
    int t, v;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 5; x++) begin
        lookup(3'(x), 11'(y), 1'b1, t, v);
        if (t != mtile[y][x])
          $display("  at %s row %0d lane %0d", tag, y, x);
        chk({tag, "_tile"}, t, mtile[y][x]);
      end
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    while (!clr_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", int'(clr_ready), 1);
  endtask

  task automatic do_clear(input int x, input int y);
    wait_ready(50);
    clr_valid = 1'b1; clr_x = 3'(x); clr_y = 11'(y);
    @(negedge clk);
    clr_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  x;
    logic [10:0] y;
    logic        pv;
    int          et;
    int          ev;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int   t, v, bc, cx, cy;
    int   et_q [2];
    int   ev_q [2];

    // rows 0..2 are safe, so every valid hit there is empty; the rest are invalid
    tbl[0] = '{3'd0, 11'd0,    1'b1, 0, 1};
    tbl[1] = '{3'd4, 11'd1,    1'b1, 0, 1};
    tbl[2] = '{3'd2, 11'd2,    1'b1, 0, 1};
    tbl[3] = '{3'd7, 11'd5,    1'b1, 0, 1};
    tbl[4] = '{3'd2, 11'h7FF,  1'b1, 0, 1};
    tbl[5] = '{3'd5, 11'd3,    1'b1, 0, 1};
    tbl[6] = '{3'd1, 11'd16,   1'b1, 0, 1};
    tbl[7] = '{3'd3, 11'd0,    1'b0, 0, 0};
    tbl[8] = '{3'd1, 11'd1024, 1'b1, 0, 1};

    rst_n = 1'b0; advance_row = 1'b0; pix_valid = 1'b0; clr_valid = 1'b0;
    index_x = 3'd0; index_y = 11'd0; clr_x = 3'd0; clr_y = 11'd0;
    repeat (2) @(negedge clk);
    chk("rst_tile_out",   int'(tile_out), 0);
    chk("rst_tile_valid", int'(tile_valid), 0);
    chk("rst_base_row",   int'(base_row), 0);
    chk("rst_busy",       int'(busy), 1);
    chk("rst_clr_ready",  int'(clr_ready), 0);

    // ---- INIT length ----
    rst_n = 1'b1;
    model_init();
    bc = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    chk("init_busy_cycles", bc, 32);
    chk("init_done_busy", int'(busy), 0);
    chk("init_done_clr_ready", int'(clr_ready), 1);

    // ---- table vectors ----
    for (int i = 0; i < 9; i++) begin
      lookup(tbl[i].x, tbl[i].y, tbl[i].pv, t, v);
      chk("vec_tile", t, tbl[i].et);
      chk("vec_valid", v, tbl[i].ev);
    end
    check_all("init");

    // ---- random back-to-back lookups ----
    for (int i = 0; i < 202; i++) begin
      logic [2:0]  rx;
      logic [10:0] ry;
      logic        rv;
      if (i >= 2) begin
        chk("rnd_valid", int'(tile_valid), ev_q[1]);
        chk("rnd_tile",  int'(tile_out),   et_q[1]);
      end
      rx = 3'($urandom_range(0, 7));
      ry = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'($urandom_range(0, 20));
      rv = 1'($urandom_range(0, 3) != 0);
      if (i >= 200) rv = 1'b0;
      index_x = rx; index_y = ry; pix_valid = rv;
      et_q[1] = et_q[0]; ev_q[1] = ev_q[0];
      ev_q[0] = int'(rv);
      et_q[0] = (rv && rx < 5 && ry < 16) ? mtile[ry][rx] : 0;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);

    // ---- single advance ----
    wait_ready(10);
    advance_row = 1'b1;
    @(negedge clk);
    advance_row = 1'b0;
    bc = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("adv1_busy_cycles", bc, 2);
    chk("adv1_base_row", int'(base_row), 1);
    model_adv();
    check_all("adv1");

    // ---- coin clear ----
    cx = -1; cy = -1;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 5; x++)
        if (cx < 0 && mtile[y][x] == 1) begin cx = x; cy = y; end
    chk("coin_found", int'(cx >= 0), 1);
    if (cx >= 0) begin
      do_clear(cx, cy);
      mtile[cy][cx] = 0;
      lookup(3'(cx), 11'(cy), 1'b1, t, v);
      chk("coin_cleared", t, 0);
    end

    // ---- clear aimed at an obstacle ----
    cx = -1; cy = -1;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 5; x++)
        if (cx < 0 && mtile[y][x] == 2) begin cx = x; cy = y; end
    chk("obstacle_found", int'(cx >= 0), 1);
    if (cx >= 0) begin
      do_clear(cx, cy);
      lookup(3'(cx), 11'(cy), 1'b1, t, v);
      chk("obstacle_kept", t, 2);
    end

    // out-of-range clears must not alias onto a real row/lane
    do_clear(1, 20);
    do_clear(6, 4);
    check_all("clr");

    // ---- reset in GEN ----
    wait_ready(10);
    advance_row = 1'b1;
    @(negedge clk);
    advance_row = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy",       int'(busy), 1);
    chk("midrst_clr_ready",  int'(clr_ready), 0);
    chk("midrst_base_row",   int'(base_row), 0);
    chk("midrst_tile_valid", int'(tile_valid), 0);
    chk("midrst_tile_out",   int'(tile_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    repeat (32) @(negedge clk);
    chk("reinit_busy", int'(busy), 0);
    check_all("reinit");

    // ---- four pulses while INIT runs: pending saturates at 3 ----
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    repeat (5) @(negedge clk);
    advance_row = 1'b1;
    repeat (4) @(negedge clk);
    advance_row = 1'b0;
    wait_ready(200);
    chk("sat_base_row", int'(base_row), 3);
    repeat (3) model_adv();
    check_all("sat");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
